gen_arb_mux: RTL
================

Name: gen_arb_mux

Overview:
- Registered, parametrised N-to-1 arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the combinational generic mux: selects a source by external select, fixed priority or round-robin, and holds the winner in a one-deep output register.
- Used wherever several EC data lanes (parity engines, stripe readers) share one downstream consumer.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- INPUTS_NUM, 3, number of input channels; legal range 2..32, need not be a power of two.
- ARB_MODE, 1, source selection: 0 = external sel, 1 = round-robin, 2 = fixed priority (lowest index wins).
- SELECT_WIDTH, $clog2(INPUTS_NUM), local parameter and not overridable; width of the index fields.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  INPUTS_NUM  per-channel valid.
- in_data  in  INPUTS_NUM*DATA_WIDTH  flattened inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  INPUTS_NUM  per-channel ready; one-hot or all zero.
- sel  in  SELECT_WIDTH  channel index, used only when ARB_MODE = 0.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_WIDTH  registered output word.
- out_src  out  SELECT_WIDTH  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): out_valid = 0, out_data = 0, out_src = 0, round-robin pointer rr_ptr = 0. in_ready is 0 during reset because out_valid is 0 and the grant is forced to 0.
- Load enable: load_en = !out_valid | out_ready.
- Grant is combinational and one-hot:
  - ARB_MODE 0: grant[sel] = in_valid[sel], valid only when sel < INPUTS_NUM. An out-of-range sel gives no grant.
  - ARB_MODE 1: first valid channel at or after rr_ptr, scanning upward and wrapping INPUTS_NUM-1 -> 0.
  - ARB_MODE 2: lowest-index valid channel.
- Ready: in_ready = grant & {INPUTS_NUM{load_en}}. in_ready does not depend on in_data. in_ready depends on in_valid only through arbitration.
- Transfer on channel g when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= channel g data, out_src <= g, out_valid <= 1.
  - rr_ptr <= (g == INPUTS_NUM-1) ? 0 : g+1.
- If load_en = 1 and there is no grant: out_valid <= 0. out_data and out_src hold their last values.
- If load_en = 0 (out_valid & !out_ready): out_valid, out_data, out_src and rr_ptr all hold. All in_ready are 0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready is held high. An output pop and a new load in the same cycle are legal and required.
- rr_ptr advances only on a transfer, never on idle cycles or in modes 0 and 2. In those modes it stays 0.
- Fairness (mode 1): with all channels continuously valid and out_ready = 1, grants cycle 0,1,...,N-1,0 with no channel skipped or repeated.
- Per-channel data ordering is preserved. No word is dropped or duplicated.
- Reset mid-transfer: the output word is discarded, out_valid goes to 0 immediately (asynchronously), and arbitration restarts at channel 0.
- Upstream protocol: a source keeps in_valid and in_data stable until it sees in_ready. The block does not check this.

Test Plan:
- Reset with traffic pending (ARB_MODE=1, INPUTS_NUM=3, all valid) -> out_valid=0, in_ready=000 while rst_n=0. First post-reset grant is ch0; out_data = ch0 word one cycle later.
- Round-robin saturation (data ch0=0x10, ch1=0x21, ch2=0x32, all valid, out_ready=1, 6 cycles) -> out_src 0,1,2,0,1,2 back-to-back; out_data 0x10,0x21,0x32 repeating.
- Backpressure: hold out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_src frozen, in_ready=000. On the release cycle, a pop and a reload occur together with no bubble.
- Sparse round-robin (only ch2 and ch0 valid, rr_ptr=1) -> ch2 granted, then ch0, then ch2. rr_ptr wraps 2->0.
- Fixed priority (ARB_MODE=2, ch1 and ch2 valid continuously) -> ch1 granted every cycle, ch2 starves. Drop ch1 -> ch2 granted on the next cycle.
- External select (ARB_MODE=0, INPUTS_NUM=3, sel=3) -> no grant; out_valid falls to 0 after the current word pops. Then sel=2 with ch2 valid (0x55) -> out_data=0x55, out_src=2.

Source files
------------

// File: rtl/gen_arb_mux.sv
// Registered N-to-1 arbitrating multiplexer with valid/ready on every input and on the output.
// The source is chosen by external select, by round-robin or by fixed priority. The winning word is held in a one-deep output register.
module gen_arb_mux #(
    parameter int DATA_WIDTH   = 8,
    parameter int INPUTS_NUM   = 3,
    parameter int ARB_MODE     = 1,
    localparam int SELECT_WIDTH = $clog2(INPUTS_NUM)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [INPUTS_NUM-1:0]            in_valid,
    input  logic [INPUTS_NUM*DATA_WIDTH-1:0] in_data,
    output logic [INPUTS_NUM-1:0]            in_ready,
    input  logic [SELECT_WIDTH-1:0]          sel,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SELECT_WIDTH-1:0]          out_src,
    input  logic                             out_ready
);

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SELECT_WIDTH-1:0] out_src_q,   out_src_d;
    logic [SELECT_WIDTH-1:0] rr_ptr_q,    rr_ptr_d;

    logic                    load_en;
    logic [INPUTS_NUM-1:0]   upper;
    logic [INPUTS_NUM-1:0]   cand;
    logic [INPUTS_NUM-1:0]   grant;
    logic                    grant_any;
    logic [SELECT_WIDTH-1:0] grant_idx;
    logic [DATA_WIDTH-1:0]   grant_data;

    assign load_en = !out_valid_q | out_ready;

    // Candidate set per mode. Round-robin prefers channels at or above rr_ptr and otherwise wraps to the lowest valid channel.
    always_comb begin
        upper = '0;
        cand  = '0;
        for (int i = 0; i < INPUTS_NUM; i++) begin
            upper[i] = in_valid[i] && (SELECT_WIDTH'(i) >= rr_ptr_q);
        end
        if (ARB_MODE == 0) begin
            for (int i = 0; i < INPUTS_NUM; i++) begin
                cand[i] = in_valid[i] && (sel == SELECT_WIDTH'(i));
            end
        end else if (ARB_MODE == 1) begin
            cand = (|upper) ? upper : in_valid;
        end else begin
            cand = in_valid;
        end
    end

    // Lowest set candidate wins. Holding reset forces the grant to zero, so in_ready stays low.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = INPUTS_NUM - 1; i >= 0; i--) begin
            if (cand[i] && rst_n) begin
                grant_any = 1'b1;
                grant_idx = SELECT_WIDTH'(i);
            end
        end
    end

    always_comb begin
        grant      = '0;
        grant_data = '0;
        for (int i = 0; i < INPUTS_NUM; i++) begin
            grant[i] = grant_any && (grant_idx == SELECT_WIDTH'(i));
            if (grant[i]) begin
                grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_ready = grant & {INPUTS_NUM{load_en}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (grant_any) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_src_d   = grant_idx;
                if (ARB_MODE == 1) begin
                    rr_ptr_d = (grant_idx == SELECT_WIDTH'(INPUTS_NUM - 1)) ? '0
                                                                             : grant_idx + SELECT_WIDTH'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
